vga_axil_bridge: RTL and testbench
==================================

# vga_axil_bridge

Sits directly upstream of `vga_top` and converts a standard AXI4-Lite slave port into the simplified strobe interface that `vga_top` consumes. That interface is `axil_wdata/wstrb/waddr/wready` for writes and `axil_rreq/raddr/rdata` for reads. The bridge serializes writes and reads and handles all valid/ready handshakes and response channels, so the SoC interconnect can drive the VGA text buffer, the character ROM and the config registers directly.

## Interface
- `C_AXI_ADDR_WIDTH`, default 15: byte address width, identical on both sides.
- `C_AXI_DATA_WIDTH`, default 32: data width; strobe width is `C_AXI_DATA_WIDTH/8`.
- `READ_LATENCY`, default 1: cycles from `axil_rreq_o` to valid `axil_rdata_i`; legal range 1..4.
- `clk_i`  in  1  single clock; all logic is rising-edge.
- `rstn_i`  in  1  asynchronous, active-low reset.
- `s_awaddr_i`, `s_awvalid_i`, `s_awready_o`: AW channel, with address width `C_AXI_ADDR_WIDTH`; `awprot` is not present.
- `s_wdata_i`, `s_wstrb_i`, `s_wvalid_i`, `s_wready_o`: W channel, DATA/STRB widths.
- `s_bresp_o` (2 bits), `s_bvalid_o`, `s_bready_i`: B channel.
- `s_araddr_i`, `s_arvalid_i`, `s_arready_o`: AR channel.
- `s_rdata_o` (DATA width), `s_rresp_o` (2 bits), `s_rvalid_o`, `s_rready_i`: R channel.
- `axil_wdata_o`, `axil_wstrb_o`, `axil_waddr_o`  out: write payload to `vga_top`; registered and held stable.
- `axil_wready_o`  out  1: one-cycle write strobe to `vga_top`.
- `axil_rreq_o`  out  1: read request; high for the whole read access.
- `axil_raddr_o`  out  ADDR: read address, stable while `axil_rreq_o` is high.
- `axil_rdata_i`  in  DATA: read data from `vga_top`.

## Operation
- **AW and W capture.** AW and W are captured independently into holding registers, so either may arrive first or both in the same cycle.
  - `s_awready_o` = AW holding register empty and state is IDLE.
  - `s_wready_o` = W holding register empty and state is IDLE.
- **FSM states:** IDLE, WRITE, WRESP, RREQ, RWAIT, RRESP.
- **IDLE arbitration.**
  - A write is eligible when both AW and W are held.
  - A read is eligible when `s_arvalid_i` is high and `s_arready_o` is high.
  - If both are eligible in the same cycle, a `last_was_write` flag arbitrates round-robin. The flag resets to 0, so the write wins first.
- **WRITE.**
  - Drive `axil_wready_o`=1 for exactly one cycle with the held data, strobe and address.
  - Clear both holding registers, then go to WRESP.
- **WRESP.**
  - `s_bvalid_o`=1 and `s_bresp_o`=2'b00 (OKAY).
  - On `s_bready_i`, return to IDLE.
- **RREQ / RWAIT.**
  - The AR handshake latches `s_araddr_i` into `axil_raddr_o` and raises `axil_rreq_o`.
  - Hold for `READ_LATENCY` cycles, then sample `axil_rdata_i` into `s_rdata_o`.
  - Drop `axil_rreq_o` and go to RRESP.
- **RRESP.**
  - `s_rvalid_o`=1 and `s_rresp_o`=OKAY; `s_rdata_o` is held until `s_rready_i`.
  - On `s_rready_i`, return to IDLE.
- **Addresses** pass through unmodified (byte addresses; `vga_top` decodes them). No SLVERR is generated.
- **Write/read ordering.** Only one transaction is in flight, so a write is always visible to a later read.

## Timing
- **Reset values:**
  - All `*ready_o`, `*valid_o`, `axil_wready_o` and `axil_rreq_o` are 0.
  - All data, address and strobe outputs are 0; both resp outputs are 2'b00.
  - State is IDLE, holding registers are empty, `last_was_write`=0.
  - `s_awready_o` and `s_wready_o` rise in the first cycle after reset deasserts.
- **Write latency:** last of AW/W handshake at cycle N → `axil_wready_o` at N+1 → `s_bvalid_o` at N+2.
- **Read latency:** AR handshake at N → `axil_rreq_o` high N+1..N+`READ_LATENCY` → `s_rvalid_o` at N+`READ_LATENCY`+1.
- **Backpressure:** all outputs must hold steady while `s_bready_i` or `s_rready_i` is low. No new AW, W or AR is accepted until the response completes.
- **Asserted flags:** once asserted, `s_bvalid_o` and `s_rvalid_o` never drop without their ready.
- **Reset mid-transaction:** all outputs return to their reset values immediately (asynchronously). Any pending write is discarded and never reaches `vga_top`.

## Structure
- Shared package `vga_axil_pkg` holds:
  - the FSM state typedef;
  - `AXI_RESP_OKAY` = 2'b00;
  - the default address and data width constants, shared with `vga_top`.
- No sub-module is needed; this is a single flat FSM plus holding registers (about 200 lines).

## Test plan
- **W before AW:** W = 32'h00000041 with strobe 4'hF; two cycles later AW = 15'h4000.
  - Required: exactly one `axil_wready_o` pulse with waddr 15'h4000 and wdata 32'h41.
  - Required: BVALID with OKAY one cycle later.
- **Same-cycle AW and W:** AW = 15'h495F, W = 32'h43000000.
  - Required: pulse at N+1 and BVALID at N+2.
- **Simultaneous write and read after reset:** write to 15'h2004 plus a read of 15'h2004.
  - Required: the write is served first, then the read.
  - Required: with `axil_rdata_i`=32'h0, RDATA=0 at the expected cycle.
- **Back-pressure:** `s_bready_i` held low for 10 cycles, with a new AR presented during that time.
  - Required: BVALID stays high and ARREADY stays 0.
  - Required: the read starts only after the B handshake.
- **Read with `READ_LATENCY`=2:** `axil_rdata_i`=32'h000000FF for a read of 15'h1040.
  - Required: `axil_rreq_o` is high for exactly 2 cycles.
  - Required: RDATA=32'hFF, held until RREADY.
- **Reset during WRESP and during RWAIT:** assert `rstn_i` low in each of those states.
  - Required: all outputs are at their reset values in the same cycle.
  - Required: no write pulse appears afterwards.

Source files
------------

// File: rtl/vga_axil_bridge_pkg.sv
// Shared types and constants for the AXI4-Lite to vga_top strobe bridge.
package vga_axil_pkg;

   localparam int unsigned VGA_ADDR_W = 15;
   localparam int unsigned VGA_DATA_W = 32;

   localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WRITE,
      ST_WRESP,
      ST_RREQ,
      ST_RWAIT,
      ST_RRESP
   } state_t;

endpackage

// File: rtl/vga_axil_bridge_if.sv
// AXI4-Lite slave channels plus the vga_top strobe side, seen from the bridge (slave) or its peers (master).
interface vga_axil_bridge_if
   import vga_axil_pkg::*;
#(
   parameter int unsigned ADDR_W = VGA_ADDR_W,
   parameter int unsigned DATA_W = VGA_DATA_W
) ();

   localparam int unsigned STRB_W = DATA_W / 8;

   logic [ADDR_W-1:0] s_awaddr_i;
   logic              s_awvalid_i;
   logic              s_awready_o;
   logic [DATA_W-1:0] s_wdata_i;
   logic [STRB_W-1:0] s_wstrb_i;
   logic              s_wvalid_i;
   logic              s_wready_o;
   logic [1:0]        s_bresp_o;
   logic              s_bvalid_o;
   logic              s_bready_i;
   logic [ADDR_W-1:0] s_araddr_i;
   logic              s_arvalid_i;
   logic              s_arready_o;
   logic [DATA_W-1:0] s_rdata_o;
   logic [1:0]        s_rresp_o;
   logic              s_rvalid_o;
   logic              s_rready_i;

   logic [DATA_W-1:0] axil_wdata_o;
   logic [STRB_W-1:0] axil_wstrb_o;
   logic [ADDR_W-1:0] axil_waddr_o;
   logic              axil_wready_o;
   logic              axil_rreq_o;
   logic [ADDR_W-1:0] axil_raddr_o;
   logic [DATA_W-1:0] axil_rdata_i;

   modport slave (
      input  s_awaddr_i, s_awvalid_i, s_wdata_i, s_wstrb_i, s_wvalid_i, s_bready_i,
      input  s_araddr_i, s_arvalid_i, s_rready_i, axil_rdata_i,
      output s_awready_o, s_wready_o, s_bresp_o, s_bvalid_o, s_arready_o,
      output s_rdata_o, s_rresp_o, s_rvalid_o,
      output axil_wdata_o, axil_wstrb_o, axil_waddr_o, axil_wready_o, axil_rreq_o, axil_raddr_o
   );

   modport master (
      output s_awaddr_i, s_awvalid_i, s_wdata_i, s_wstrb_i, s_wvalid_i, s_bready_i,
      output s_araddr_i, s_arvalid_i, s_rready_i, axil_rdata_i,
      input  s_awready_o, s_wready_o, s_bresp_o, s_bvalid_o, s_arready_o,
      input  s_rdata_o, s_rresp_o, s_rvalid_o,
      input  axil_wdata_o, axil_wstrb_o, axil_waddr_o, axil_wready_o, axil_rreq_o, axil_raddr_o
   );

endinterface

// File: rtl/vga_axil_bridge.sv
// AXI4-Lite slave to vga_top strobe bridge: one transaction in flight, round-robin
// between a fully held write and a pending read.
module vga_axil_bridge
   import vga_axil_pkg::*;
#(
   parameter int unsigned C_AXI_ADDR_WIDTH = VGA_ADDR_W,
   parameter int unsigned C_AXI_DATA_WIDTH = VGA_DATA_W,
   parameter int unsigned READ_LATENCY     = 1
) (
   input  logic              clk_i,
   input  logic              rstn_i,
   vga_axil_bridge_if.slave  bus
);

   localparam int unsigned STRB_W   = C_AXI_DATA_WIDTH / 8;
   localparam logic [2:0]  CNT_LAST = 3'(READ_LATENCY - 1);

   state_t                      r_state;
   state_t                      w_state_nxt;
   logic                        r_rdy_en;
   logic                        r_aw_full;
   logic                        r_w_full;
   logic                        r_last_wr;
   logic [C_AXI_ADDR_WIDTH-1:0] r_awaddr;
   logic [C_AXI_DATA_WIDTH-1:0] r_wdata;
   logic [STRB_W-1:0]           r_wstrb;
   logic [C_AXI_ADDR_WIDTH-1:0] r_raddr;
   logic [C_AXI_DATA_WIDTH-1:0] r_rdata;
   logic [2:0]                  r_cnt;

   logic w_idle;
   logic w_awready;
   logic w_wready;
   logic w_arready;
   logic w_aw_hs;
   logic w_w_hs;
   logic w_wr_elig;
   logic w_rd_elig;
   logic w_pick_wr;
   logic w_rd_cap;
   logic w_bvalid;
   logic w_rvalid;
   logic w_wstb;
   logic w_rreq;

   assign w_idle    = (r_state == ST_IDLE);
   assign w_awready = r_rdy_en & w_idle & ~r_aw_full;
   assign w_wready  = r_rdy_en & w_idle & ~r_w_full;
   assign w_aw_hs   = bus.s_awvalid_i & w_awready;
   assign w_w_hs    = bus.s_wvalid_i & w_wready;
   assign w_wr_elig = (r_aw_full | w_aw_hs) & (r_w_full | w_w_hs);
   // ARREADY is withheld when the write owns this arbitration slot, so an AR is never accepted and then dropped
   assign w_arready = r_rdy_en & w_idle & ~(w_wr_elig & ~r_last_wr);
   assign w_rd_elig = bus.s_arvalid_i & w_arready;
   assign w_pick_wr = w_idle & w_wr_elig & ~w_rd_elig;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_rd_cap    = 1'b0;
      w_bvalid    = 1'b0;
      w_rvalid    = 1'b0;
      w_wstb      = 1'b0;
      w_rreq      = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (w_rd_elig) begin
               w_state_nxt = ST_RREQ;
            end else if (w_pick_wr) begin
               w_state_nxt = ST_WRITE;
            end
         end
         ST_WRITE: begin
            w_wstb      = 1'b1;
            w_state_nxt = ST_WRESP;
         end
         ST_WRESP: begin
            w_bvalid = 1'b1;
            if (bus.s_bready_i) w_state_nxt = ST_IDLE;
         end
         ST_RREQ: begin
            w_rreq = 1'b1;
            if (READ_LATENCY <= 1) begin
               w_rd_cap    = 1'b1;
               w_state_nxt = ST_RRESP;
            end else begin
               w_state_nxt = ST_RWAIT;
            end
         end
         ST_RWAIT: begin
            w_rreq = 1'b1;
            if (r_cnt == CNT_LAST) begin
               w_rd_cap    = 1'b1;
               w_state_nxt = ST_RRESP;
            end
         end
         ST_RRESP: begin
            w_rvalid = 1'b1;
            if (bus.s_rready_i) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_rdy_en  <= 1'b0;
         r_aw_full <= 1'b0;
         r_w_full  <= 1'b0;
         r_last_wr <= 1'b0;
         r_awaddr  <= '0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
         r_raddr   <= '0;
         r_rdata   <= '0;
         r_cnt     <= '0;
      end else begin
         r_rdy_en <= 1'b1;
         if (w_aw_hs) begin
            r_aw_full <= 1'b1;
            r_awaddr  <= bus.s_awaddr_i;
         end
         if (w_w_hs) begin
            r_w_full <= 1'b1;
            r_wdata  <= bus.s_wdata_i;
            r_wstrb  <= bus.s_wstrb_i;
         end
         // Payload stays on the vga_top outputs after the strobe; only the full flags are released
         if (r_state == ST_WRITE) begin
            r_aw_full <= 1'b0;
            r_w_full  <= 1'b0;
         end
         if (w_pick_wr) begin
            r_last_wr <= 1'b1;
         end else if (w_rd_elig) begin
            r_last_wr <= 1'b0;
         end
         if (w_rd_elig) r_raddr <= bus.s_araddr_i;
         if (r_state == ST_RREQ) begin
            r_cnt <= 3'd1;
         end else if (r_state == ST_RWAIT) begin
            r_cnt <= r_cnt + 3'd1;
         end
         if (w_rd_cap) r_rdata <= bus.axil_rdata_i;
      end
   end

   assign bus.s_awready_o   = w_awready;
   assign bus.s_wready_o    = w_wready;
   assign bus.s_arready_o   = w_arready;
   assign bus.s_bvalid_o    = w_bvalid;
   assign bus.s_bresp_o     = AXI_RESP_OKAY;
   assign bus.s_rvalid_o    = w_rvalid;
   assign bus.s_rresp_o     = AXI_RESP_OKAY;
   assign bus.s_rdata_o     = r_rdata;
   assign bus.axil_wdata_o  = r_wdata;
   assign bus.axil_wstrb_o  = r_wstrb;
   assign bus.axil_waddr_o  = r_awaddr;
   assign bus.axil_wready_o = w_wstb;
   assign bus.axil_rreq_o   = w_rreq;
   assign bus.axil_raddr_o  = r_raddr;

endmodule

// File: tb/tb_vga_axil_bridge.sv
// Scenario bench for vga_axil_bridge with READ_LATENCY=2; expected writes/reads are queued at stimulus time.
module tb_vga_axil_bridge;
  import vga_axil_pkg::*;

  localparam int unsigned AW = 15;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;
  localparam int unsigned RL = 2;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
  } wr_t;

  logic clk;
  logic rstn;
  int   checks     = 0;
  int   failures   = 0;
  int   n_wr_pulse = 0;
  wr_t           exp_wr[$];
  logic [DW-1:0] exp_rd[$];

  vga_axil_bridge_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  vga_axil_bridge #(
    .C_AXI_ADDR_WIDTH(AW),
    .C_AXI_DATA_WIDTH(DW),
    .READ_LATENCY(RL)
  ) dut (
    .clk_i (clk),
    .rstn_i(rstn),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rstn === 1'b1 && bus.axil_wready_o === 1'b1) n_wr_pulse++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.s_awaddr_i   = '0;
    bus.s_awvalid_i  = 1'b0;
    bus.s_wdata_i    = '0;
    bus.s_wstrb_i    = '0;
    bus.s_wvalid_i   = 1'b0;
    bus.s_bready_i   = 1'b1;
    bus.s_araddr_i   = '0;
    bus.s_arvalid_i  = 1'b0;
    bus.s_rready_i   = 1'b1;
    bus.axil_rdata_i = '0;
  endtask

  task automatic reset_pulse();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.s_awready_o, bus.s_wready_o, bus.s_arready_o} !== 3'b000) begin
      failures++;
      $display("FAIL reset_ready: got %b required 000", {bus.s_awready_o, bus.s_wready_o, bus.s_arready_o});
    end
    checks++;
    if ({bus.s_bvalid_o, bus.s_rvalid_o, bus.axil_wready_o, bus.axil_rreq_o} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_valid: got %b required 0000",
               {bus.s_bvalid_o, bus.s_rvalid_o, bus.axil_wready_o, bus.axil_rreq_o});
    end
    checks++;
    if ({bus.axil_wdata_o, bus.axil_wstrb_o, bus.axil_waddr_o, bus.axil_raddr_o, bus.s_rdata_o} !== '0) begin
      failures++;
      $display("FAIL reset_data: got %h required 0",
               {bus.axil_wdata_o, bus.axil_wstrb_o, bus.axil_waddr_o, bus.axil_raddr_o, bus.s_rdata_o});
    end
    checks++;
    if ({bus.s_bresp_o, bus.s_rresp_o} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_resp: got %b required 0000", {bus.s_bresp_o, bus.s_rresp_o});
    end
    @(posedge clk);
    #1 rstn = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if ({bus.s_awready_o, bus.s_wready_o, bus.s_arready_o} !== 3'b111) begin
      failures++;
      $display("FAIL ready_after_reset: got %b required 111", {bus.s_awready_o, bus.s_wready_o, bus.s_arready_o});
    end
  endtask

  task automatic test_w_before_aw();
    int  p0;
    wr_t e;
    tick();
    p0 = n_wr_pulse;
    bus.s_wvalid_i = 1'b1;
    bus.s_wdata_i  = 32'h0000_0041;
    bus.s_wstrb_i  = 4'hF;
    exp_wr.push_back(wr_t'{15'h4000, 32'h0000_0041, 4'hF});
    tick();
    bus.s_wvalid_i = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.s_wready_o, bus.s_awready_o, bus.axil_wready_o} !== 3'b010) begin
      failures++;
      $display("FAIL w_held_wait: got wready/awready/strobe=%b required 010",
               {bus.s_wready_o, bus.s_awready_o, bus.axil_wready_o});
    end
    tick();
    bus.s_awvalid_i = 1'b1;
    bus.s_awaddr_i  = 15'h4000;
    tick();
    bus.s_awvalid_i = 1'b0;
    @(negedge clk);
    e = exp_wr.pop_front();
    checks++;
    if (bus.axil_wready_o !== 1'b1 || {bus.axil_waddr_o, bus.axil_wdata_o, bus.axil_wstrb_o} !== e) begin
      failures++;
      $display("FAIL w_before_aw_pulse: got strobe=%b payload=%h required strobe=1 payload=%h",
               bus.axil_wready_o, {bus.axil_waddr_o, bus.axil_wdata_o, bus.axil_wstrb_o}, e);
    end
    @(negedge clk);
    checks++;
    if ({bus.s_bvalid_o, bus.s_bresp_o, bus.axil_wready_o} !== {1'b1, AXI_RESP_OKAY, 1'b0}) begin
      failures++;
      $display("FAIL w_before_aw_b: got bvalid=%b bresp=%b strobe=%b required 1 00 0",
               bus.s_bvalid_o, bus.s_bresp_o, bus.axil_wready_o);
    end
    repeat (4) tick();
    checks++;
    if (n_wr_pulse - p0 !== 1) begin
      failures++;
      $display("FAIL w_before_aw_count: got %0d pulses required 1", n_wr_pulse - p0);
    end
  endtask

  task automatic test_same_cycle();
    wr_t e;
    bus.s_awvalid_i = 1'b1;
    bus.s_awaddr_i  = 15'h495F;
    bus.s_wvalid_i  = 1'b1;
    bus.s_wdata_i   = 32'h4300_0000;
    bus.s_wstrb_i   = 4'hF;
    exp_wr.push_back(wr_t'{15'h495F, 32'h4300_0000, 4'hF});
    tick();
    bus.s_awvalid_i = 1'b0;
    bus.s_wvalid_i  = 1'b0;
    @(negedge clk);
    e = exp_wr.pop_front();
    checks++;
    if (bus.axil_wready_o !== 1'b1 || {bus.axil_waddr_o, bus.axil_wdata_o, bus.axil_wstrb_o} !== e) begin
      failures++;
      $display("FAIL same_cycle_pulse: got strobe=%b payload=%h required strobe=1 payload=%h",
               bus.axil_wready_o, {bus.axil_waddr_o, bus.axil_wdata_o, bus.axil_wstrb_o}, e);
    end
    @(negedge clk);
    checks++;
    if ({bus.s_bvalid_o, bus.s_bresp_o} !== {1'b1, AXI_RESP_OKAY}) begin
      failures++;
      $display("FAIL same_cycle_b: got bvalid=%b bresp=%b required 1 00", bus.s_bvalid_o, bus.s_bresp_o);
    end
    repeat (2) tick();
  endtask

  task automatic test_arbitration();
    wr_t           e;
    logic [DW-1:0] er;
    reset_pulse();
    bus.s_awvalid_i  = 1'b1;
    bus.s_awaddr_i   = 15'h2004;
    bus.s_wvalid_i   = 1'b1;
    bus.s_wdata_i    = 32'hA5A5_0001;
    bus.s_wstrb_i    = 4'h3;
    bus.s_arvalid_i  = 1'b1;
    bus.s_araddr_i   = 15'h2004;
    bus.axil_rdata_i = 32'h0;
    exp_wr.push_back(wr_t'{15'h2004, 32'hA5A5_0001, 4'h3});
    exp_rd.push_back(32'h0);
    @(negedge clk);
    checks++;
    if ({bus.s_awready_o, bus.s_arready_o} !== 2'b10) begin
      failures++;
      $display("FAIL arb_write_first: got awready/arready=%b required 10", {bus.s_awready_o, bus.s_arready_o});
    end
    tick();
    bus.s_awvalid_i = 1'b0;
    bus.s_wvalid_i  = 1'b0;
    @(negedge clk);
    e = exp_wr.pop_front();
    checks++;
    if (bus.axil_wready_o !== 1'b1 || bus.axil_rreq_o !== 1'b0 ||
        {bus.axil_waddr_o, bus.axil_wdata_o, bus.axil_wstrb_o} !== e) begin
      failures++;
      $display("FAIL arb_pulse: got strobe=%b rreq=%b payload=%h required 1 0 %h",
               bus.axil_wready_o, bus.axil_rreq_o, {bus.axil_waddr_o, bus.axil_wdata_o, bus.axil_wstrb_o}, e);
    end
    @(negedge clk);
    checks++;
    if ({bus.s_bvalid_o, bus.s_arready_o} !== 2'b10) begin
      failures++;
      $display("FAIL arb_b: got bvalid/arready=%b required 10", {bus.s_bvalid_o, bus.s_arready_o});
    end
    @(negedge clk);
    checks++;
    if (bus.s_arready_o !== 1'b1) begin
      failures++;
      $display("FAIL arb_ar_after_b: got arready=%b required 1", bus.s_arready_o);
    end
    tick();
    bus.s_arvalid_i = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.axil_rreq_o !== 1'b1 || bus.axil_raddr_o !== 15'h2004) begin
      failures++;
      $display("FAIL arb_rreq: got rreq=%b raddr=%h required 1 2004", bus.axil_rreq_o, bus.axil_raddr_o);
    end
    @(negedge clk);
    @(negedge clk);
    er = exp_rd.pop_front();
    checks++;
    if (bus.s_rvalid_o !== 1'b1 || bus.s_rdata_o !== er || bus.s_rresp_o !== AXI_RESP_OKAY) begin
      failures++;
      $display("FAIL arb_rdata: got rvalid=%b rdata=%h rresp=%b required 1 %h 00",
               bus.s_rvalid_o, bus.s_rdata_o, bus.s_rresp_o, er);
    end
    repeat (2) tick();
  endtask

  task automatic test_back_pressure();
    wr_t           e;
    logic [DW-1:0] er;
    bit            done = 0;
    bus.s_bready_i  = 1'b0;
    bus.s_awvalid_i = 1'b1;
    bus.s_awaddr_i  = 15'h0010;
    bus.s_wvalid_i  = 1'b1;
    bus.s_wdata_i   = 32'h1234_5678;
    bus.s_wstrb_i   = 4'hF;
    exp_wr.push_back(wr_t'{15'h0010, 32'h1234_5678, 4'hF});
    tick();
    bus.s_awvalid_i  = 1'b0;
    bus.s_wvalid_i   = 1'b0;
    bus.s_arvalid_i  = 1'b1;
    bus.s_araddr_i   = 15'h0020;
    bus.axil_rdata_i = 32'h0000_0055;
    exp_rd.push_back(32'h0000_0055);
    @(negedge clk);
    e = exp_wr.pop_front();
    checks++;
    if (bus.axil_wready_o !== 1'b1 || {bus.axil_waddr_o, bus.axil_wdata_o, bus.axil_wstrb_o} !== e) begin
      failures++;
      $display("FAIL bp_pulse: got strobe=%b payload=%h required 1 %h",
               bus.axil_wready_o, {bus.axil_waddr_o, bus.axil_wdata_o, bus.axil_wstrb_o}, e);
    end
    for (int unsigned i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.s_bvalid_o, bus.s_arready_o, bus.s_awready_o, bus.s_wready_o, bus.axil_rreq_o} !== 5'b10000) begin
        failures++;
        $display("FAIL bp_hold_%0d: got bvalid/arready/awready/wready/rreq=%b required 10000", i,
                 {bus.s_bvalid_o, bus.s_arready_o, bus.s_awready_o, bus.s_wready_o, bus.axil_rreq_o});
      end
    end
    tick();
    bus.s_bready_i = 1'b1;
    for (int unsigned i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (bus.s_arready_o === 1'b1) begin
        @(posedge clk);
        #1 bus.s_arvalid_i = 1'b0;
      end
      if (bus.s_rvalid_o === 1'b1) done = 1;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL bp_read_timeout: got no rvalid required rvalid within 20 cycles");
    end else begin
      er = exp_rd.pop_front();
      if (bus.s_rdata_o !== er) begin
        failures++;
        $display("FAIL bp_rdata: got %h required %h", bus.s_rdata_o, er);
      end
    end
    bus.s_arvalid_i = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_read_latency();
    logic [DW-1:0] er;
    int            n_rreq = 0;
    bit            done   = 0;
    bus.s_rready_i   = 1'b0;
    bus.s_arvalid_i  = 1'b1;
    bus.s_araddr_i   = 15'h1040;
    bus.axil_rdata_i = 32'h0000_00FF;
    exp_rd.push_back(32'h0000_00FF);
    tick();
    bus.s_arvalid_i = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.axil_rreq_o !== 1'b1 || bus.axil_raddr_o !== 15'h1040) begin
      failures++;
      $display("FAIL rl_first: got rreq=%b raddr=%h required 1 1040", bus.axil_rreq_o, bus.axil_raddr_o);
    end
    if (bus.axil_rreq_o === 1'b1) n_rreq++;
    for (int unsigned i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (bus.axil_rreq_o === 1'b1) n_rreq++;
      if (bus.s_rvalid_o === 1'b1) done = 1;
    end
    checks++;
    if (!done || n_rreq != RL) begin
      failures++;
      $display("FAIL rl_rreq_cycles: got rvalid_seen=%0d rreq_cycles=%0d required 1 %0d", done, n_rreq, RL);
    end
    bus.axil_rdata_i = 32'hDEAD_BEEF;
    for (int unsigned i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (bus.s_rvalid_o !== 1'b1 || bus.s_rdata_o !== 32'h0000_00FF) begin
        failures++;
        $display("FAIL rl_hold_%0d: got rvalid=%b rdata=%h required 1 000000ff", i, bus.s_rvalid_o, bus.s_rdata_o);
      end
    end
    tick();
    bus.s_rready_i = 1'b1;
    @(negedge clk);
    er = exp_rd.pop_front();
    checks++;
    if (bus.s_rvalid_o !== 1'b1 || bus.s_rdata_o !== er) begin
      failures++;
      $display("FAIL rl_rdata: got rvalid=%b rdata=%h required 1 %h", bus.s_rvalid_o, bus.s_rdata_o, er);
    end
    @(negedge clk);
    checks++;
    if (bus.s_rvalid_o !== 1'b0) begin
      failures++;
      $display("FAIL rl_rvalid_drop: got rvalid=%b required 0", bus.s_rvalid_o);
    end
    tick();
  endtask

  task automatic test_reset_wresp();
    wr_t e;
    int  p0;
    bus.s_bready_i  = 1'b0;
    bus.s_awvalid_i = 1'b1;
    bus.s_awaddr_i  = 15'h0300;
    bus.s_wvalid_i  = 1'b1;
    bus.s_wdata_i   = 32'h0000_0077;
    bus.s_wstrb_i   = 4'h1;
    exp_wr.push_back(wr_t'{15'h0300, 32'h0000_0077, 4'h1});
    tick();
    bus.s_awvalid_i = 1'b0;
    bus.s_wvalid_i  = 1'b0;
    @(negedge clk);
    e = exp_wr.pop_front();
    checks++;
    if (bus.axil_wready_o !== 1'b1 || {bus.axil_waddr_o, bus.axil_wdata_o, bus.axil_wstrb_o} !== e) begin
      failures++;
      $display("FAIL rst_wresp_pulse: got strobe=%b payload=%h required 1 %h",
               bus.axil_wready_o, {bus.axil_waddr_o, bus.axil_wdata_o, bus.axil_wstrb_o}, e);
    end
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({bus.s_bvalid_o, bus.s_awready_o, bus.s_wready_o, bus.s_arready_o, bus.axil_wready_o} !== 5'b00000 ||
        {bus.axil_waddr_o, bus.axil_wdata_o, bus.axil_wstrb_o} !== '0) begin
      failures++;
      $display("FAIL rst_wresp_outputs: got flags=%b payload=%h required 00000 0",
               {bus.s_bvalid_o, bus.s_awready_o, bus.s_wready_o, bus.s_arready_o, bus.axil_wready_o},
               {bus.axil_waddr_o, bus.axil_wdata_o, bus.axil_wstrb_o});
    end
    p0 = n_wr_pulse;
    bus.s_bready_i = 1'b1;
    tick();
    rstn = 1'b1;
    repeat (10) tick();
    checks++;
    if (n_wr_pulse != p0 || bus.s_bvalid_o !== 1'b0) begin
      failures++;
      $display("FAIL rst_wresp_after: got pulses=%0d bvalid=%b required 0 0", n_wr_pulse - p0, bus.s_bvalid_o);
    end
  endtask

  task automatic test_reset_rwait();
    int p0;
    bus.s_awvalid_i  = 1'b1;
    bus.s_awaddr_i   = 15'h0500;
    bus.s_arvalid_i  = 1'b1;
    bus.s_araddr_i   = 15'h0600;
    bus.axil_rdata_i = 32'h0000_0009;
    tick();
    bus.s_awvalid_i = 1'b0;
    bus.s_arvalid_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.axil_rreq_o !== 1'b1 || bus.axil_raddr_o !== 15'h0600) begin
      failures++;
      $display("FAIL rst_rwait_pre: got rreq=%b raddr=%h required 1 0600", bus.axil_rreq_o, bus.axil_raddr_o);
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({bus.axil_rreq_o, bus.s_rvalid_o, bus.s_arready_o, bus.s_awready_o} !== 4'b0000 ||
        {bus.axil_raddr_o, bus.s_rdata_o, bus.axil_waddr_o} !== '0) begin
      failures++;
      $display("FAIL rst_rwait_outputs: got flags=%b addr_data=%h required 0000 0",
               {bus.axil_rreq_o, bus.s_rvalid_o, bus.s_arready_o, bus.s_awready_o},
               {bus.axil_raddr_o, bus.s_rdata_o, bus.axil_waddr_o});
    end
    tick();
    rstn = 1'b1;
    tick();
    p0 = n_wr_pulse;
    bus.s_wvalid_i = 1'b1;
    bus.s_wdata_i  = 32'h0000_00AA;
    bus.s_wstrb_i  = 4'hF;
    tick();
    bus.s_wvalid_i = 1'b0;
    repeat (10) tick();
    checks++;
    if (n_wr_pulse != p0 || bus.s_rvalid_o !== 1'b0) begin
      failures++;
      $display("FAIL rst_rwait_discard: got pulses=%0d rvalid=%b required 0 0", n_wr_pulse - p0, bus.s_rvalid_o);
    end
  endtask

  initial begin
    test_reset();
    test_w_before_aw();
    test_same_cycle();
    test_arbitration();
    test_back_pressure();
    test_read_latency();
    test_reset_wresp();
    test_reset_rwait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    if (failures == 0) $display("PASS");
    else $display("FAIL");
    $finish;
  end

endmodule
